// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers ALU and load results and drains one per cycle
// into the register file write port. Optional FORWARD_EN adds queue lookups.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_reg,
    input  logic [DW-1:0]            mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [AW-1:0]            alu_reg,
    input  logic [DW-1:0]            alu_data,
    output logic                     RegWrite,
    output logic [AW-1:0]            WriteReg,
    output logic [DW-1:0]            WriteData,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
`ifdef FORWARD_EN
    ,
    input  logic [AW-1:0]            fwd_reg1,
    input  logic [AW-1:0]            fwd_reg2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [AW-1:0] regMem  [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [PW-1:0] aluSlot;
    logic [PW:0]   countReg;
    logic [PW:0]   freeSlots;
    logic [PW:0]   aluNeed;
    logic          memNeed;
    logic          memPush;
    logic          aluPush;
    logic          pop;

    assign count     = countReg;
    assign freeSlots = DEPTH_C - countReg;
    assign memNeed   = mem_valid && (mem_reg != '0);
    assign aluNeed   = (PW+1)'(1) + (PW+1)'(memNeed);

    // Readies look only at the registered count; a same-cycle pop earns no credit.
    assign mem_ready = !rst && (freeSlots >= (PW+1)'(1));
    assign alu_ready = !rst && (freeSlots >= aluNeed);

    // Register-0 writes complete the handshake but never occupy a slot.
    assign memPush = mem_valid && mem_ready && (mem_reg != '0);
    assign aluPush = alu_valid && alu_ready && (alu_reg != '0);
    assign pop     = (countReg != '0);
    assign aluSlot = tailPtr + PW'(memPush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
        end else begin
            headPtr  <= headPtr + PW'(pop);
            tailPtr  <= tailPtr + PW'(memPush) + PW'(aluPush);
            countReg <= countReg + (PW+1)'(memPush) + (PW+1)'(aluPush) - (PW+1)'(pop);
        end
    end

    // The load result is older, so it takes the tail slot ahead of the ALU result.
    always_ff @(posedge clk) begin
        if (memPush) begin
            regMem[tailPtr]  <= mem_reg;
            dataMem[tailPtr] <= mem_data;
        end
        if (aluPush) begin
            regMem[aluSlot]  <= alu_reg;
            dataMem[aluSlot] <= alu_data;
        end
    end

    assign RegWrite  = pop;
    assign WriteReg  = pop ? regMem[headPtr]  : '0;
    assign WriteData = pop ? dataMem[headPtr] : '0;

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < countReg) begin
                pending = pending | (32'd1 << regMem[headPtr + PW'(k)]);
            end
        end
        pending[0] = 1'b0;
    end

`ifdef FORWARD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < countReg) begin
                if (fwd_reg1 != '0 && regMem[headPtr + PW'(k)] == fwd_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = dataMem[headPtr + PW'(k)];
                end
                if (fwd_reg2 != '0 && regMem[headPtr + PW'(k)] == fwd_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = dataMem[headPtr + PW'(k)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4).
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_reg = '0;
    logic [DW-1:0] mem_data = '0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_reg = '0;
    logic [DW-1:0] alu_data = '0;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [31:0]   pending;
    logic [2:0]    count;
`ifdef FORWARD_EN
    logic [AW-1:0] fwd_reg1 = '0;
    logic [AW-1:0] fwd_reg2 = '0;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
`endif

    int checks = 0;
    int errors = 0;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .pending   (pending),
        .count     (count)
`ifdef FORWARD_EN
        ,
        .fwd_reg1  (fwd_reg1),
        .fwd_reg2  (fwd_reg2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                                 input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad);
        mem_valid = mv;
        mem_reg   = mr;
        mem_data  = md;
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held: everything quiet, readies low
        repeat (2) tick();
        checkOutput("rst_regwrite", 64'(RegWrite), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_pending", 64'(pending), 64'd0);
        checkOutput("rst_memready", 64'(mem_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_memready", 64'(mem_ready), 64'd1);
        checkOutput("rel_aluready", 64'(alu_ready), 64'd1);

        // Single ALU write to r5
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        checkOutput("t2_aluready", 64'(alu_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t2_regwrite", 64'(RegWrite), 64'd1);
        checkOutput("t2_writereg", 64'(WriteReg), 64'd5);
        checkOutput("t2_writedata", 64'(WriteData), 64'hDEADBEEF);
        checkOutput("t2_pending", 64'(pending), 64'h20);
        checkOutput("t2_count", 64'(count), 64'd1);
        tick();
        checkOutput("t2_pending_clr", 64'(pending), 64'd0);
        checkOutput("t2_regwrite_clr", 64'(RegWrite), 64'd0);

        // Simultaneous mem r3 and alu r4: mem first
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        checkOutput("t3_aluready", 64'(alu_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t3_count2", 64'(count), 64'd2);
        checkOutput("t3_reg_a", 64'(WriteReg), 64'd3);
        checkOutput("t3_data_a", 64'(WriteData), 64'h11);
        checkOutput("t3_pending_a", 64'(pending), 64'h18);
        tick();
        checkOutput("t3_reg_b", 64'(WriteReg), 64'd4);
        checkOutput("t3_data_b", 64'(WriteData), 64'h22);
        checkOutput("t3_pending_b", 64'(pending), 64'h10);
        tick();
        checkOutput("t3_empty", 64'(count), 64'd0);

        // Fill: two pairs back to back, then a third pair with only one free slot
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
        tick();
        checkOutput("t4_count2", 64'(count), 64'd2);
        checkOutput("t4_reg1", 64'(WriteReg), 64'd1);
        applyStimulus(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
        #1;
        checkOutput("t4_aluready_free2", 64'(alu_ready), 64'd1);
        tick();
        checkOutput("t4_count3", 64'(count), 64'd3);
        checkOutput("t4_reg2", 64'(WriteReg), 64'd2);
        checkOutput("t4_pending3", 64'(pending), 64'h1C);
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd6, 32'hA6);
        #1;
        checkOutput("t4_aluready_r0mem", 64'(alu_ready), 64'd1);
        applyStimulus(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6);
        #1;
        checkOutput("t4_memready_free1", 64'(mem_ready), 64'd1);
        checkOutput("t4_aluready_free1", 64'(alu_ready), 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t4_count_hold", 64'(count), 64'd3);
        checkOutput("t4_reg3", 64'(WriteReg), 64'd3);
        checkOutput("t4_data3", 64'(WriteData), 64'hA3);
        checkOutput("t4_pending_345", 64'(pending), 64'h38);
        tick();
        checkOutput("t4_reg4", 64'(WriteReg), 64'd4);
        tick();
        checkOutput("t4_reg5", 64'(WriteReg), 64'd5);
        checkOutput("t4_data5", 64'(WriteData), 64'hA5);
        tick();
        checkOutput("t4_drained", 64'(count), 64'd0);
        checkOutput("t4_drained_rw", 64'(RegWrite), 64'd0);

        // Register 0 write is accepted and dropped
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        #1;
        checkOutput("t5_aluready", 64'(alu_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t5_count", 64'(count), 64'd0);
        checkOutput("t5_regwrite", 64'(RegWrite), 64'd0);
        checkOutput("t5_writedata", 64'(WriteData), 64'd0);

        // Reset mid-operation flushes the queue
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t1_count_pre", 64'(count), 64'd2);
        rst = 1'b1;
        #1;
        checkOutput("t1_count", 64'(count), 64'd0);
        checkOutput("t1_regwrite", 64'(RegWrite), 64'd0);
        checkOutput("t1_writereg", 64'(WriteReg), 64'd0);
        checkOutput("t1_writedata", 64'(WriteData), 64'd0);
        checkOutput("t1_pending", 64'(pending), 64'd0);
        checkOutput("t1_aluready_rst", 64'(alu_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t1_memready_rel", 64'(mem_ready), 64'd1);
        checkOutput("t1_aluready_rel", 64'(alu_ready), 64'd1);
        checkOutput("t1_count_rel", 64'(count), 64'd0);

`ifdef FORWARD_EN
        // Two queued writes to r7: youngest data forwarded
        fwd_reg1 = 5'd7;
        fwd_reg2 = 5'd0;
        applyStimulus(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t6_hit1", 64'(fwd_hit1), 64'd1);
        checkOutput("t6_data1", 64'(fwd_data1), 64'd2);
        checkOutput("t6_hit2_r0", 64'(fwd_hit2), 64'd0);
        tick();
        checkOutput("t6_hit1_head", 64'(fwd_hit1), 64'd1);
        checkOutput("t6_data1_head", 64'(fwd_data1), 64'd2);
        tick();
        checkOutput("t6_hit1_gone", 64'(fwd_hit1), 64'd0);
        checkOutput("t6_data1_gone", 64'(fwd_data1), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
